spi_ram_arbiter: RTL and testbench



---
 rtl/spi_ram_arbiter_pkg.sv | 16 +
 rtl/spi_ram_arbiter_if.sv | 49 ++++
 rtl/spi_ram_arbiter_rr_arb2.sv | 22 ++
 rtl/spi_ram_arbiter.sv | 130 +++++++++++++
 tb/tb_spi_ram_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_arbiter_pkg.sv
// rtl/spi_ram_arbiter_pkg.sv - shared types and constants for the SPI RAM arbiter
package spi_ram_arbiter_pkg;

  // Arbiter FSM encoding; fixed 2-bit so the state register is easy to probe.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Port indices, also used as the bit position in the request vector.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// rtl/spi_ram_arbiter_if.sv - requester ports and RAM controller bundle
interface spi_ram_arbiter_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_BITS = 16
) ();

  // Requester port A
  logic [ADDR_BITS-1:0] a_addr;
  logic [DATA_W-1:0]    a_wdata;
  logic                 a_rd_req;
  logic                 a_wr_req;
  logic [DATA_W-1:0]    a_rdata;
  logic                 a_ack;

  // Requester port B
  logic [ADDR_BITS-1:0] b_addr;
  logic [DATA_W-1:0]    b_wdata;
  logic                 b_rd_req;
  logic                 b_wr_req;
  logic [DATA_W-1:0]    b_rdata;
  logic                 b_ack;

  // SPI RAM controller side
  logic [ADDR_BITS-1:0] ram_addr;
  logic [DATA_W-1:0]    ram_wdata;
  logic                 ram_start_read;
  logic                 ram_start_write;
  logic [DATA_W-1:0]    ram_rdata;
  logic                 ram_busy;

  // Arbiter view
  modport slave (
    input  a_addr, a_wdata, a_rd_req, a_wr_req,
    input  b_addr, b_wdata, b_rd_req, b_wr_req,
    input  ram_rdata, ram_busy,
    output a_rdata, a_ack, b_rdata, b_ack,
    output ram_addr, ram_wdata, ram_start_read, ram_start_write
  );

  // Environment view: requesters plus controller
  modport master (
    output a_addr, a_wdata, a_rd_req, a_wr_req,
    output b_addr, b_wdata, b_rd_req, b_wr_req,
    output ram_rdata, ram_busy,
    input  a_rdata, a_ack, b_rdata, b_ack,
    input  ram_addr, ram_wdata, ram_start_read, ram_start_write
  );

endinterface

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// rtl/spi_ram_arbiter_rr_arb2.sv - two-way round-robin chooser
module rr_arb2
  import spi_ram_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_valid
);

  // Lone requester wins outright; on a tie the port not served last wins.
  always_comb begin
    o_valid = |i_req;
    o_grant = PORT_A;
    if (i_req[PORT_A] && i_req[PORT_B]) begin
      o_grant = (i_last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (i_req[PORT_B]) begin
      o_grant = PORT_B;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - two-port arbiter in front of a single SPI RAM controller
module spi_ram_arbiter
  import spi_ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = 4,
  parameter int ADDR_BITS        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  spi_ram_arbiter_if.slave bus
);

  localparam int DATA_W = 8 * DATA_WIDTH_BYTES;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_last_grant;
  logic                 r_grant;
  logic                 r_is_write;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_a_rdata;
  logic [DATA_W-1:0]    r_b_rdata;

  logic                 w_a_req;
  logic                 w_b_req;
  logic                 w_grant;
  logic                 w_valid;
  logic                 w_win_write;
  logic [ADDR_BITS-1:0] w_win_addr;
  logic [DATA_W-1:0]    w_win_wdata;
  logic                 w_rd_done;

  assign w_a_req = bus.a_rd_req | bus.a_wr_req;
  assign w_b_req = bus.b_rd_req | bus.b_wr_req;

  rr_arb2 u_rr_arb2 (
    .i_req        ({w_b_req, w_a_req}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  // A simultaneous rd+wr from one port is treated as a write; the read is dropped.
  assign w_win_write = (w_grant == PORT_B) ? bus.b_wr_req : bus.a_wr_req;
  assign w_win_addr  = (w_grant == PORT_B) ? bus.b_addr   : bus.a_addr;
  assign w_win_wdata = (w_grant == PORT_B) ? bus.b_wdata  : bus.a_wdata;

  // Read data is taken on the edge that leaves WAIT, i.e. when the controller goes idle.
  assign w_rd_done = (r_state == ST_WAIT) && !bus.ram_busy && !r_is_write;

  // Controller sees only the latched transaction, so it is stable START through ACK.
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.a_rdata   = r_a_rdata;
  assign bus.b_rdata   = r_b_rdata;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Transaction latch, round-robin history and per-port read data
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_grant <= PORT_B;
      r_grant      <= PORT_A;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_valid) begin
        r_grant    <= w_grant;
        r_is_write <= w_win_write;
        r_addr     <= w_win_addr;
        r_wdata    <= w_win_wdata;
      end
      if (w_rd_done && (r_grant == PORT_A)) begin
        r_a_rdata <= bus.ram_rdata;
      end
      if (w_rd_done && (r_grant == PORT_B)) begin
        r_b_rdata <= bus.ram_rdata;
      end
      if (r_state == ST_ACK) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // Next state plus start/ack decode; starts only in START, acks only in ACK
  always_comb begin
    w_next_state        = r_state;
    bus.ram_start_read  = 1'b0;
    bus.ram_start_write = 1'b0;
    bus.a_ack           = 1'b0;
    bus.b_ack           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        bus.ram_start_read  = !r_is_write;
        bus.ram_start_write = r_is_write;
        w_next_state        = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.ram_busy) begin
          w_next_state = ST_ACK;
        end
      end
      ST_ACK: begin
        bus.a_ack    = (r_grant == PORT_A);
        bus.b_ack    = (r_grant == PORT_B);
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - directed self-checking bench for spi_ram_arbiter
module tb_spi_ram_arbiter;
  import spi_ram_arbiter_pkg::*;

  logic clk;
  logic rstn;

  spi_ram_arbiter_if #(.DATA_W(32), .ADDR_BITS(16)) bus_if ();

  spi_ram_arbiter #(.DATA_WIDTH_BYTES(4), .ADDR_BITS(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller stub: busy for 56 cycles after a start, data looked up from address
  int          stub_cnt;
  logic [15:0] stub_wr_addr;
  logic [31:0] stub_wr_data;

  function automatic logic [31:0] stub_value(input logic [15:0] addr);
    if (addr == 16'h1234) return 32'hDEADBEEF;
    return {addr, ~addr};
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      stub_cnt         <= 0;
      bus_if.ram_rdata <= '0;
      stub_wr_addr     <= '0;
      stub_wr_data     <= '0;
    end else if (bus_if.ram_start_read || bus_if.ram_start_write) begin
      stub_cnt         <= 56;
      bus_if.ram_rdata <= stub_value(bus_if.ram_addr);
      if (bus_if.ram_start_write) begin
        stub_wr_addr <= bus_if.ram_addr;
        stub_wr_data <= bus_if.ram_wdata;
      end
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign bus_if.ram_busy = (stub_cnt != 0);

  // Cycle counter and event monitor
  int          cyc = 0;
  int          n_rd_start = 0, n_wr_start = 0, n_a_ack = 0, n_b_ack = 0;
  int          last_start_cyc = 0, last_a_ack_cyc = 0;
  int          n_both_ack = 0, n_bad_start = 0;
  logic [15:0] last_start_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.ram_start_read)  n_rd_start++;
    if (bus_if.ram_start_write) n_wr_start++;
    if (bus_if.ram_start_read || bus_if.ram_start_write) begin
      last_start_cyc  = cyc;
      last_start_addr = bus_if.ram_addr;
      if (dut.r_state != ST_START) n_bad_start++;
    end
    if (bus_if.a_ack) begin n_a_ack++; last_a_ack_cyc = cyc; end
    if (bus_if.b_ack) n_b_ack++;
    if (bus_if.a_ack && bus_if.b_ack) n_both_ack++;
  end

  // Wait for the given port's ack, dropping its requests in the ack cycle
  task automatic wait_ack(input logic port, input string tag, output int lat);
    bit done = 0;
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (port == PORT_A && bus_if.a_ack) begin
        bus_if.a_rd_req = 0; bus_if.a_wr_req = 0; done = 1; break;
      end
      if (port == PORT_B && bus_if.b_ack) begin
        bus_if.b_rd_req = 0; bus_if.b_wr_req = 0; done = 1; break;
      end
    end
    if (!done) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    #1;
  endtask

  int lat, c0, rd0, wr0, aa0, ba0, bad, rem_a, rem_b, n_ord;
  logic [3:0] order;
  bit done;

  initial begin
    rstn = 0;
    bus_if.a_addr = '0; bus_if.a_wdata = '0; bus_if.a_rd_req = 0; bus_if.a_wr_req = 0;
    bus_if.b_addr = '0; bus_if.b_wdata = '0; bus_if.b_rd_req = 0; bus_if.b_wr_req = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_state",  dut.r_state, ST_IDLE);
    check_eq("rst_a_rdata", bus_if.a_rdata, 0);
    check_eq("rst_b_rdata", bus_if.b_rdata, 0);
    check_eq("rst_start",  {bus_if.ram_start_read, bus_if.ram_start_write}, 0);
    check_eq("rst_acks",   {bus_if.a_ack, bus_if.b_ack}, 0);
    check_eq("rst_addr",   bus_if.ram_addr, 0);
    check_eq("rst_last_grant", dut.r_last_grant, 1);
    rstn = 1;
    repeat (2) @(negedge clk);
    #1;

    // A read 0x1234: start at cycle 1, ack at cycle 59
    c0 = cyc; rd0 = n_rd_start; wr0 = n_wr_start;
    bus_if.a_addr = 16'h1234; bus_if.a_rd_req = 1;
    wait_ack(PORT_A, "t1", lat);
    check_eq("t1_latency",   lat, 59);
    check_eq("t1_ack_cyc",   last_a_ack_cyc - c0, 59);
    check_eq("t1_start_cyc", last_start_cyc - c0, 1);
    check_eq("t1_rd_starts", n_rd_start - rd0, 1);
    check_eq("t1_wr_starts", n_wr_start - wr0, 0);
    check_eq("t1_addr",      last_start_addr, 16'h1234);
    check_eq("t1_a_rdata",   bus_if.a_rdata, 32'hDEADBEEF);
    check_eq("t1_b_rdata",   bus_if.b_rdata, 0);

    // B write 0x0010 <- 0x01020304, wdata held until ack
    rd0 = n_rd_start; wr0 = n_wr_start;
    bus_if.b_addr = 16'h0010; bus_if.b_wdata = 32'h01020304; bus_if.b_wr_req = 1;
    bad = 0; done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dut.r_state != ST_IDLE &&
          (bus_if.ram_wdata !== 32'h01020304 || bus_if.ram_addr !== 16'h0010)) bad++;
      if (bus_if.b_ack) begin bus_if.b_wr_req = 0; done = 1; break; end
    end
    #1;
    check_eq("t2_done",      done, 1);
    check_eq("t2_stable",    bad, 0);
    check_eq("t2_wr_starts", n_wr_start - wr0, 1);
    check_eq("t2_rd_starts", n_rd_start - rd0, 0);
    check_eq("t2_stub_addr", stub_wr_addr, 16'h0010);
    check_eq("t2_stub_data", stub_wr_data, 32'h01020304);
    check_eq("t2_a_rdata",   bus_if.a_rdata, 32'hDEADBEEF);
    check_eq("t2_b_rdata",   bus_if.b_rdata, 0);

    // A and B reads held together: order A,B,A,B
    aa0 = n_a_ack; ba0 = n_b_ack;
    rem_a = 2; rem_b = 2; n_ord = 0; order = '0; bad = 0;
    bus_if.a_addr = 16'h0A00; bus_if.b_addr = 16'h0B00;
    bus_if.a_rd_req = 1; bus_if.b_rd_req = 1;
    for (int i = 0; i < 600 && (rem_a > 0 || rem_b > 0); i++) begin
      @(negedge clk);
      if (bus_if.a_ack && bus_if.b_ack) bad++;
      if (bus_if.a_ack) begin
        rem_a--; if (n_ord < 4) order[3 - n_ord] = PORT_A; n_ord++;
        if (rem_a == 0) bus_if.a_rd_req = 0;
      end
      if (bus_if.b_ack) begin
        rem_b--; if (n_ord < 4) order[3 - n_ord] = PORT_B; n_ord++;
        if (rem_b == 0) bus_if.b_rd_req = 0;
      end
    end
    #1;
    check_eq("t3_order",   order, 4'b0101);
    check_eq("t3_n_acks",  n_ord, 4);
    check_eq("t3_both",    bad, 0);
    check_eq("t3_a_acks",  n_a_ack - aa0, 2);
    check_eq("t3_b_acks",  n_b_ack - ba0, 2);
    check_eq("t3_a_rdata", bus_if.a_rdata, 32'h0A00F5FF);
    check_eq("t3_b_rdata", bus_if.b_rdata, 32'h0B00F4FF);

    // A rd+wr together: one write only
    rd0 = n_rd_start; wr0 = n_wr_start; aa0 = n_a_ack;
    bus_if.a_addr = 16'h0040; bus_if.a_wdata = 32'hCAFEF00D;
    bus_if.a_rd_req = 1; bus_if.a_wr_req = 1;
    wait_ack(PORT_A, "t4", lat);
    repeat (5) @(negedge clk);
    #1;
    check_eq("t4_wr_starts", n_wr_start - wr0, 1);
    check_eq("t4_rd_starts", n_rd_start - rd0, 0);
    check_eq("t4_a_acks",    n_a_ack - aa0, 1);
    check_eq("t4_stub_data", stub_wr_data, 32'hCAFEF00D);
    check_eq("t4_stub_addr", stub_wr_addr, 16'h0040);
    check_eq("t4_a_rdata",   bus_if.a_rdata, 32'h0A00F5FF);

    // Reset mid-WAIT aborts without ack
    aa0 = n_a_ack;
    bus_if.a_addr = 16'h0100; bus_if.a_rd_req = 1;
    repeat (10) @(negedge clk);
    check_eq("t5_in_wait", dut.r_state, ST_WAIT);
    rstn = 0; bus_if.a_rd_req = 0;
    @(negedge clk);
    rstn = 1;
    check_eq("t5_state",   dut.r_state, ST_IDLE);
    check_eq("t5_a_rdata", bus_if.a_rdata, 0);
    check_eq("t5_b_rdata", bus_if.b_rdata, 0);
    repeat (70) @(negedge clk);
    #1;
    check_eq("t5_no_ack",  n_a_ack - aa0, 0);
    c0 = cyc;
    bus_if.b_addr = 16'h0B0B; bus_if.b_rd_req = 1;
    wait_ack(PORT_B, "t5b", lat);
    check_eq("t5_b_latency", lat, 59);
    check_eq("t5_b_rdata",   bus_if.b_rdata, 32'h0B0BF4F4);
    check_eq("t5_a_rdata2",  bus_if.a_rdata, 0);

    // B arrives during A's WAIT: B's start 2 cycles after a_ack
    bus_if.a_addr = 16'h0200; bus_if.a_rd_req = 1;
    repeat (5) @(negedge clk);
    bus_if.b_addr = 16'h0300; bus_if.b_rd_req = 1;
    wait_ack(PORT_A, "t6a", lat);
    wait_ack(PORT_B, "t6b", lat);
    check_eq("t6_gap",     last_start_cyc - last_a_ack_cyc, 2);
    check_eq("t6_b_addr",  last_start_addr, 16'h0300);
    check_eq("t6_a_rdata", bus_if.a_rdata, 32'h0200FDFF);
    check_eq("t6_b_rdata", bus_if.b_rdata, 32'h0300FCFF);

    // Global invariants
    check_eq("never_both_ack", n_both_ack, 0);
    check_eq("start_only_in_start", n_bad_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
